sfq_dfft_array: RTL

- Cycle-based, synthesisable model of an N-channel bank of RSFQ clocked D flip-flops with toggle-encoded output (DFFT). All channels share one SFQ clock.
- Sits in the RSFQ cell-library emulation flow, where SFQ pulses are carried as transitions on NRZ-toggle wires and sampled by a fast system clock.
- Generalises the single-cell DFFT in three ways: parametrised channel count, clock-to-q latency expressed in cycles, and critical-timing windows with sticky error reporting and a saturating error counter in place of X propagation.

---
 rtl/sfq_cell_pkg.sv | 21 ++
 rtl/sfq_dfft_chan.sv | 82 ++++++++
 rtl/sfq_dfft_array.sv | 83 ++++++++
 3 files changed

// File: rtl/sfq_cell_pkg.sv
// Shared types and helpers for the RSFQ cell emulation models.
// Pulses travel as transitions on NRZ-toggle wires.
package sfq_cell_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cell_st_e;

  localparam int DELAY_DEF    = 4;
  localparam int CT_CLK_A_DEF = 1;
  localparam int CT_A_CLK_DEF = 1;

  function automatic logic tgl_pulse(
    input logic cur,
    input logic prev
  );
    return cur ^ prev;
  endfunction

endpackage

// File: rtl/sfq_dfft_chan.sv
// One DFFT channel: stored bit, timing windows,
// clock-to-q delay line and toggle output.
module sfq_dfft_chan
  import sfq_cell_pkg::*;
#(
  parameter int DELAY_CYC = DELAY_DEF,
  parameter int CT_CLK_A  = CT_CLK_A_DEF,
  parameter int CT_A_CLK  = CT_A_CLK_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_p,
  input  logic s_p,
  output logic q,
  output logic viol
);

  localparam int WA_W =
    (CT_CLK_A > 0) ? $clog2(CT_CLK_A + 1) : 1;
  localparam int WC_W =
    (CT_A_CLK > 0) ? $clog2(CT_A_CLK + 1) : 1;

  cell_st_e             st_q, st_n;
  logic [WA_W-1:0]      wa_q, wa_n;
  logic [WC_W-1:0]      wc_q, wc_n;
  logic [DELAY_CYC-1:0] dl_q;
  logic [DELAY_CYC:0]   dl_ext;
  logic                 push;
  logic                 a_o, s_o, both;

  assign both = a_p & s_p;
  assign a_o  = a_p & ~s_p;
  assign s_o  = s_p & ~a_p;

  always_comb begin
    st_n = st_q;
    wa_n = (wa_q != '0) ? wa_q - WA_W'(1) : '0;
    wc_n = (wc_q != '0) ? wc_q - WC_W'(1) : '0;
    push = 1'b0;
    viol = 1'b0;
    unique case (1'b1)
      both: viol = 1'b1;
      (st_q == ST_EMPTY) && a_o: begin
        if (wa_q != '0) viol = 1'b1;
        else            st_n = ST_FULL;
      end
      (st_q == ST_EMPTY) && s_o:
        wa_n = WA_W'(CT_CLK_A);
      (st_q == ST_FULL) && s_o: begin
        if (wc_q != '0) begin
          viol = 1'b1;
        end else begin
          push = 1'b1;
          st_n = ST_EMPTY;
        end
      end
      (st_q == ST_FULL) && a_o:
        wc_n = WC_W'(CT_A_CLK);
      default: ;
    endcase
  end

  // dl_ext keeps the shift legal for a one-stage line
  assign dl_ext = {dl_q, push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_EMPTY;
      wa_q <= '0;
      wc_q <= '0;
      dl_q <= '0;
      q    <= 1'b0;
    end else begin
      st_q <= st_n;
      wa_q <= wa_n;
      wc_q <= wc_n;
      dl_q <= dl_ext[DELAY_CYC-1:0];
      q    <= q ^ dl_q[DELAY_CYC-1];
    end
  end

endmodule

// File: rtl/sfq_dfft_array.sv
// N-channel DFFT bank on a shared SFQ clock with
// sticky per-channel flags and a saturating error count.
module sfq_dfft_array
  import sfq_cell_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DELAY_CYC = DELAY_DEF,
  parameter int CT_CLK_A  = CT_CLK_A_DEF,
  parameter int CT_A_CLK  = CT_A_CLK_DEF,
  parameter int ERR_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] a_tgl,
  input  logic                sclk_tgl,
  input  logic                err_clr,
  output logic [CHANNELS-1:0] q_tgl,
  output logic [CHANNELS-1:0] err_flag,
  output logic [ERR_W-1:0]    err_count
);

  localparam int CW = $clog2(CHANNELS + 1);
  localparam int SW = ERR_W + CW;

  logic [CHANNELS-1:0] a_d, a_p, viol;
  logic [CHANNELS-1:0] flag_n;
  logic                s_d, s_p;
  logic [CW-1:0]       vcnt;
  logic [ERR_W-1:0]    base, cnt_n;
  logic [SW-1:0]       sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_d <= '0;
      s_d <= 1'b0;
    end else begin
      a_d <= a_tgl;
      s_d <= sclk_tgl;
    end
  end

  assign s_p = tgl_pulse(sclk_tgl, s_d);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign a_p[i] = tgl_pulse(a_tgl[i], a_d[i]);
    sfq_dfft_chan #(
      .DELAY_CYC (DELAY_CYC),
      .CT_CLK_A  (CT_CLK_A),
      .CT_A_CLK  (CT_A_CLK)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .a_p   (a_p[i]),
      .s_p   (s_p),
      .q     (q_tgl[i]),
      .viol  (viol[i])
    );
  end

  always_comb begin
    vcnt = '0;
    for (int i = 0; i < CHANNELS; i++)
      vcnt = vcnt + CW'(viol[i]);
  end

  // a same-cycle clear still records this cycle's violations
  assign base   = err_clr ? '0 : err_count;
  assign sum    = SW'(base) + SW'(vcnt);
  assign cnt_n  = (|sum[SW-1:ERR_W]) ? '1
                                     : sum[ERR_W-1:0];
  assign flag_n = (err_clr ? '0 : err_flag) | viol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag  <= '0;
      err_count <= '0;
    end else begin
      err_flag  <= flag_n;
      err_count <= cnt_n;
    end
  end

endmodule
